// File: rtl/clk_period_meter.sv
// Measures the period of sigIn in inClk cycles, with a sticky no-signal timeout.
// Define CLK_PERIOD_METER_AVG_EN to report the truncated mean of every 4 periods.
module clk_period_meter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic             inClk,
    input  logic             reset,
    input  logic             sigIn,
    output logic [WIDTH-1:0] period_count,
    output logic             period_valid,
    output logic             locked,
    output logic             no_signal
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_e;

    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic rise;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pv_q, pv_d;
    logic             ns_q, ns_d;

`ifdef CLK_PERIOD_METER_AVG_EN
    logic [WIDTH+1:0] acc_q, acc_d;
    logic [1:0]       ph_q, ph_d;
    logic [WIDTH+1:0] sum;
`endif

    // sigIn is asynchronous; two flops before edge detection
    always_ff @(posedge inClk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sigIn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;

    always_ff @(posedge inClk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            pv_q    <= 1'b0;
            ns_q    <= 1'b0;
`ifdef CLK_PERIOD_METER_AVG_EN
            acc_q   <= '0;
            ph_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            pv_q    <= pv_d;
            ns_q    <= ns_d;
`ifdef CLK_PERIOD_METER_AVG_EN
            acc_q   <= acc_d;
            ph_q    <= ph_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        pv_d    = 1'b0;
        ns_d    = ns_q;
`ifdef CLK_PERIOD_METER_AVG_EN
        acc_d   = acc_q;
        ph_d    = ph_q;
        sum     = acc_q + {2'b00, cnt_q};
`endif
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = ONE_W;
                    ns_d    = 1'b0;
                end
            end
            MEASURE: begin
                // a rise coinciding with the timeout still counts as a period
                if (rise) begin
                    cnt_d = ONE_W;
`ifdef CLK_PERIOD_METER_AVG_EN
                    if (ph_q == 2'd3) begin
                        pc_d  = sum[WIDTH+1:2];
                        pv_d  = 1'b1;
                        acc_d = '0;
                        ph_d  = '0;
                    end else begin
                        acc_d = sum;
                        ph_d  = ph_q + 2'd1;
                    end
`else
                    pc_d = cnt_q;
                    pv_d = 1'b1;
`endif
                end else if (cnt_q == TIMEOUT_W) begin
                    state_d = IDLE;
                    ns_d    = 1'b1;
                    cnt_d   = '0;
`ifdef CLK_PERIOD_METER_AVG_EN
                    acc_d   = '0;
                    ph_d    = '0;
`endif
                end else begin
                    cnt_d = cnt_q + ONE_W;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign period_count = pc_q;
    assign period_valid = pv_q;
    assign locked       = (state_q == MEASURE);
    assign no_signal    = ns_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: expected periods are queued at each
// generated sigIn rise and popped by a monitor on every period_valid pulse.
module tb_clk_period_meter;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 100;

    logic             clk;
    logic             reset;
    logic             sigIn;
    logic [WIDTH-1:0] period_count;
    logic             period_valid;
    logic             locked;
    logic             no_signal;

    int total = 0;
    int bad   = 0;

    int exp_q[$];
    int exp_pc   = 0;
    bit armed    = 0;
    int last_len = 0;
    bit watch_lock = 0;
    int lock_drops = 0;
`ifdef CLK_PERIOD_METER_AVG_EN
    int acc_m = 0;
    int ph_m  = 0;
`endif

    clk_period_meter #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .inClk        (clk),
        .reset        (reset),
        .sigIn        (sigIn),
        .period_count (period_count),
        .period_valid (period_valid),
        .locked       (locked),
        .no_signal    (no_signal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected report for one completed period of length len
    task automatic report(input int len, output bit fired);
`ifdef CLK_PERIOD_METER_AVG_EN
        acc_m += len;
        ph_m++;
        fired = 1'b0;
        if (ph_m == 4) begin
            exp_q.push_back(acc_m / 4);
            exp_pc = acc_m / 4;
            acc_m  = 0;
            ph_m   = 0;
            fired  = 1'b1;
        end
`else
        exp_q.push_back(len);
        exp_pc = len;
        fired  = 1'b1;
`endif
    endtask

    task automatic model_clear();
        armed = 1'b0;
`ifdef CLK_PERIOD_METER_AVG_EN
        acc_m = 0;
        ph_m  = 0;
`endif
    endtask

    // One full period starting with a rise; rise-to-rise spacing equals p
    task automatic run_period(input int p);
        bit f;
        if (armed) report(last_len, f);
        armed    = 1'b1;
        last_len = p;
        sigIn = 1'b1;
        repeat (p / 2) @(negedge clk);
        sigIn = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    task automatic timeout_test();
        bit f;
        if (armed) report(last_len, f);
        armed = 1'b1;
        sigIn = 1'b1;
        repeat (10) @(negedge clk);
        sigIn = 1'b0;
        // counter restarts 3 edges after sigIn is driven; timeout 100 later
        repeat (92) @(negedge clk);
        check("no_signal_pre_timeout", no_signal, 0);
        check("locked_pre_timeout", locked, 1);
        @(negedge clk);
        check("no_signal_timeout", no_signal, 1);
        check("locked_timeout", locked, 0);
        check("period_hold_timeout", period_count, exp_pc);
        model_clear();
    endtask

    task automatic reset_test();
        bit f;
        if (armed) report(last_len, f);
        sigIn = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        sigIn = 1'b0;
        #1;
        check("rst_mid_period_count", period_count, 0);
        check("rst_mid_valid", period_valid, 0);
        check("rst_mid_locked", locked, 0);
        check("rst_mid_no_signal", no_signal, 0);
        model_clear();
        @(negedge clk);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic latency_test();
        bit f;
        f = 1'b0;
        if (armed) report(last_len, f);
        armed    = 1'b1;
        last_len = 10;
        sigIn = 1'b1;
        @(negedge clk);
        check("latency_E", period_valid, 0);
        @(negedge clk);
        check("latency_E1", period_valid, 0);
        @(negedge clk);
        check("latency_E2", period_valid, {31'd0, f});
        @(negedge clk);
        check("latency_E3", period_valid, 0);
        @(negedge clk);
        sigIn = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset && period_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got period_count %0d expected no pulse",
                         period_count);
            end else begin
                check("period_count", period_count, exp_q.pop_front());
            end
            check("locked_on_valid", locked, 1);
        end
    end

    always @(negedge clk) begin
        if (watch_lock && !locked) lock_drops++;
    end

    initial begin
        reset = 1'b1;
        sigIn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_period_count", period_count, 0);
        check("rst_valid", period_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_no_signal", no_signal, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) run_period(4);
        check("locked_p4", locked, 1);

        watch_lock = 1'b1;
        for (int i = 0; i < 5; i++) run_period(10);
        for (int i = 0; i < 5; i++) run_period(20);
        watch_lock = 1'b0;
        check("lock_drops_switch", lock_drops, 0);

        timeout_test();
        run_period(10);
        check("no_signal_cleared", no_signal, 0);
        check("locked_rearm", locked, 1);
        run_period(10);
        run_period(10);

        reset_test();
        run_period(8);
        run_period(8);
        run_period(10);
        run_period(10);
        run_period(5);
        run_period(5);
        run_period(5);
        run_period(6);
        run_period(10);

        latency_test();
        run_period(10);
        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
